// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the 12-LED pattern sequencer.
//   - LED bus width, speed index width and saturation limit
//   - pattern mode enum (cycle order ROT_L -> ROT_R -> PINGPONG -> BLINK)
//   - run/pause state enum and pingpong direction encoding
//   - seed patterns loaded on a mode change
//   - helper functions for the next mode in the cycle and its seed
package led_pkg;

  localparam int LED_W   = 12;
  localparam int SPEED_W = 3;

  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
  localparam logic [SPEED_W-1:0] SPEED_MIN = 3'd0;

  localparam logic [LED_W-1:0] SEED_L  = 12'h001;
  localparam logic [LED_W-1:0] SEED_R  = 12'h800;
  localparam logic [LED_W-1:0] SEED_ON = 12'hFFF;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ROT_L    = 2'd0,
    ROT_R    = 2'd1,
    PINGPONG = 2'd2,
    BLINK    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_e;

  // Next mode in the user-visible cycle order.
  function automatic mode_e mode_succ(input mode_e m);
    mode_e r;
    case (m)
      ROT_L:    r = ROT_R;
      ROT_R:    r = PINGPONG;
      PINGPONG: r = BLINK;
      BLINK:    r = ROT_L;
      default:  r = ROT_L;
    endcase
    return r;
  endfunction

  // Pattern shown immediately after entering a mode.
  function automatic logic [LED_W-1:0] mode_seed(input mode_e m);
    logic [LED_W-1:0] r;
    case (m)
      ROT_L:    r = SEED_L;
      ROT_R:    r = SEED_R;
      PINGPONG: r = SEED_L;
      BLINK:    r = SEED_ON;
      default:  r = SEED_L;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// led_step_timer: step prescaler. Counts 0..P-1 with P = TIME_BASE*(speed+1)
// and flags the terminal count so the controller updates the pattern on the
// following edge.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   en    in   count enable (RUN state); the count holds while low
//   clr   in   synchronous clear of the count (mode or speed change)
//   speed in   speed index 0..7, selects the period
//   step  out  combinational terminal-count flag, only while en is high
module led_step_timer
  import led_pkg::*;
#(
  parameter int TIME_BASE = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  localparam int CNT_W = $clog2(TIME_BASE * 8);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] last_s;

  // Terminal count value for the selected speed.
  always_comb begin
    last_s = CNT_W'(TIME_BASE * (int'(speed) + 1) - 1);
  end

  assign step = en && (count_r == last_s);

  // Prescaler counter; clear has priority, the count holds while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (step) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: pattern sequencer for the 12-LED bar. Owns the pattern
// mode, the speed index, the RUN/PAUSE state and the pattern register; the
// prescaler lives in led_step_timer.
// Configuration macro: LED_KEY_SYNC_EN -- when defined, each key input gets a
// 2-flop synchronizer and rising-edge detector (3-cycle key latency); when
// undefined, keys are synchronous single-cycle pulses acting on the next edge.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   mode_next in   pulse: advance to the next pattern mode
//   speed_up  in   pulse: speed index -1 (faster), saturates at 0
//   speed_dn  in   pulse: speed index +1 (slower), saturates at 7
//   pause_tgl in   pulse: toggle RUN/PAUSE
//   dout      out  LED drive, 1 = LED on
//   mode      out  current mode
//   speed     out  current speed index
//   paused    out  1 while in PAUSE
//   step      out  one-cycle pulse on each pattern update
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int TIME_BASE  = 5_000_000,
  parameter int SPEED_INIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_next,
  input  logic               speed_up,
  input  logic               speed_dn,
  input  logic               pause_tgl,
  output logic [LED_W-1:0]   dout,
  output logic [1:0]         mode,
  output logic [SPEED_W-1:0] speed,
  output logic               paused,
  output logic               step
);

  logic mode_key_s, up_key_s, dn_key_s, pause_key_s;

`ifdef LED_KEY_SYNC_EN
  logic [3:0] meta_r, sync_r, prev_r;

  // Key synchronizer chain plus previous-value stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 4'b0000;
      sync_r <= 4'b0000;
      prev_r <= 4'b0000;
    end else begin
      meta_r <= {mode_next, speed_up, speed_dn, pause_tgl};
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign {mode_key_s, up_key_s, dn_key_s, pause_key_s} = sync_r & ~prev_r;
`else
  assign {mode_key_s, up_key_s, dn_key_s, pause_key_s} =
         {mode_next, speed_up, speed_dn, pause_tgl};
`endif

  run_state_e         state_r, state_nxt_s;
  logic               run_s, paused_s;
  mode_e              mode_r, mode_nxt_s;
  logic [LED_W-1:0]   dout_r, dout_nxt_s, shifted_s;
  logic               dir_r, dir_nxt_s;
  logic [SPEED_W-1:0] speed_r, speed_nxt_s;
  logic               speed_chg_s;
  logic               step_r, step_nxt_s;
  logic               tc_s;

  // RUN/PAUSE state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // RUN/PAUSE next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN:   state_nxt_s = pause_key_s ? ST_PAUSE : ST_RUN;
      ST_PAUSE: state_nxt_s = pause_key_s ? ST_RUN : ST_PAUSE;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // RUN/PAUSE state outputs.
  always_comb begin
    run_s    = 1'b1;
    paused_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        run_s    = 1'b1;
        paused_s = 1'b0;
      end
      ST_PAUSE: begin
        run_s    = 1'b0;
        paused_s = 1'b1;
      end
      default: begin
        run_s    = 1'b1;
        paused_s = 1'b0;
      end
    endcase
  end

  // Speed index update; conflicting keys and saturated presses change nothing.
  always_comb begin
    speed_nxt_s = speed_r;
    speed_chg_s = 1'b0;
    if (up_key_s && !dn_key_s && (speed_r != SPEED_MIN)) begin
      speed_nxt_s = speed_r - 3'd1;
      speed_chg_s = 1'b1;
    end else if (dn_key_s && !up_key_s && (speed_r != SPEED_MAX)) begin
      speed_nxt_s = speed_r + 3'd1;
      speed_chg_s = 1'b1;
    end else begin
      speed_nxt_s = speed_r;
      speed_chg_s = 1'b0;
    end
  end

  led_step_timer #(
    .TIME_BASE(TIME_BASE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (run_s),
    .clr  (mode_key_s | speed_chg_s),
    .speed(speed_r),
    .step (tc_s)
  );

  // Pingpong single-bit shift in the current direction.
  always_comb begin
    if (dir_r == DIR_RIGHT) begin
      shifted_s = {1'b0, dout_r[LED_W-1:1]};
    end else begin
      shifted_s = {dout_r[LED_W-2:0], 1'b0};
    end
  end

  // Pattern/mode update. A mode change beats a coincident terminal count:
  // the seed loads and no step is issued.
  always_comb begin
    mode_nxt_s = mode_r;
    dout_nxt_s = dout_r;
    dir_nxt_s  = dir_r;
    step_nxt_s = 1'b0;
    if (mode_key_s) begin
      mode_nxt_s = mode_succ(mode_r);
      dout_nxt_s = mode_seed(mode_succ(mode_r));
      dir_nxt_s  = DIR_LEFT;
    end else if (tc_s) begin
      step_nxt_s = 1'b1;
      case (mode_r)
        ROT_L: dout_nxt_s = {dout_r[LED_W-2:0], dout_r[LED_W-1]};
        ROT_R: dout_nxt_s = {dout_r[0], dout_r[LED_W-1:1]};
        PINGPONG: begin
          dout_nxt_s = shifted_s;
          // Reverse on the step that lands on an end so no end value repeats.
          if (shifted_s == SEED_R) begin
            dir_nxt_s = DIR_RIGHT;
          end else if (shifted_s == SEED_L) begin
            dir_nxt_s = DIR_LEFT;
          end else begin
            dir_nxt_s = dir_r;
          end
        end
        BLINK:   dout_nxt_s = ~dout_r;
        default: dout_nxt_s = SEED_L;
      endcase
    end else begin
      step_nxt_s = 1'b0;
    end
  end

  // Pattern, mode, speed and step registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r  <= ROT_L;
      dout_r  <= SEED_L;
      dir_r   <= DIR_LEFT;
      speed_r <= SPEED_W'(SPEED_INIT);
      step_r  <= 1'b0;
    end else begin
      mode_r  <= mode_nxt_s;
      dout_r  <= dout_nxt_s;
      dir_r   <= dir_nxt_s;
      speed_r <= speed_nxt_s;
      step_r  <= step_nxt_s;
    end
  end

  assign dout   = dout_r;
  assign mode   = mode_r;
  assign speed  = speed_r;
  assign paused = paused_s;
  assign step   = step_r;

endmodule
